// File: rtl/diff_freq_serializer_pkg.sv
// Shared constants and types for the dual-rate serializer.
// Idle-mode encodings, speed selects and the two-state FSM type.
// Also holds the idle-line level helper used by the top.
package diff_freq_serializer_pkg;

  localparam logic [1:0] IDLE_LOW    = 2'b00;
  localparam logic [1:0] IDLE_HIGH   = 2'b01;
  localparam logic [1:0] IDLE_KEEP   = 2'b10;
  localparam logic [1:0] IDLE_REPEAT = 2'b11;

  localparam logic LOW_SPEED  = 1'b0;
  localparam logic HIGH_SPEED = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Line level between frames. Repeat mode never idles on its own, so it
  // shares the idle-low level (also what it collapses to when repeat is off).
  function automatic logic idle_level(input logic [1:0] mode, input logic last_bit);
    case (mode)
      IDLE_HIGH: return 1'b1;
      IDLE_KEEP: return last_bit;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/diff_freq_serializer_bit_period_timer.sv
// Bit-period timer: 8-bit up counter that wraps at i_load-1.
// Latency: o_tc is combinational on the cycle the count equals i_load-1.
// No backpressure; i_clr forces the count to zero and wins over counting.
module bit_period_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [7:0] i_load,
  output logic       o_tc
);

  logic [7:0] r_cnt;
  logic       w_tc;

  assign w_tc = i_en && (r_cnt == (i_load - 8'd1));
  assign o_tc = w_tc;

  // Count clock cycles within one bit period, wrapping on terminal count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/diff_freq_serializer.sv
// Dual-rate LSB-first parallel-to-serial transmitter with one-cycle done tick.
// Latency: bit0 on o_data one cycle after start; done tick DATA_BIT*N+1 cycles after start.
// No backpressure: i_start ignored while sending; i_stop aborts at once.
// Optional repeat mode (idle mode 11) compiled in with DIFF_FREQ_REPEAT_EN.
module diff_freq_serializer
  import diff_freq_serializer_pkg::*;
#(
  parameter int DATA_BIT  = 8,
  parameter int LOW_FREQ  = 20,
  parameter int HIGH_FREQ = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sel_freq,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [1:0]          i_idle_mode,
  input  logic [DATA_BIT-1:0] i_data,
  output logic                o_data,
  output logic                o_done_tick
);

  localparam int            IW       = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BIT - 1);
  localparam logic [7:0]    LOW_N    = 8'(LOW_FREQ);
  localparam logic [7:0]    HIGH_N   = 8'(HIGH_FREQ);

  state_t              r_state;
  logic [DATA_BIT-1:0] r_word;
  logic                r_sel;
  logic [1:0]          r_mode;
  logic [IW-1:0]       r_idx;
  logic                r_fend;
  logic                r_data;
  logic                r_done;

  logic       w_send;
  logic       w_accept;
  logic       w_tc;
  logic       w_last;
  logic       w_frame_end;
  logic       w_line;
  logic [7:0] w_period;

  assign w_send      = (r_state == SEND);
  assign w_accept    = (r_state == IDLE) && i_start && !i_stop;
  assign w_period    = (r_sel == HIGH_SPEED) ? HIGH_N : LOW_N;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_frame_end = w_send && w_tc && w_last && !i_stop;
  // Next line value; registered below so bit0 appears one cycle after start.
  assign w_line      = w_send ? r_word[r_idx] : idle_level(r_mode, r_word[DATA_BIT-1]);

  bit_period_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_send),
    .i_clr  (!w_send || i_stop),
    .i_load (w_period),
    .o_tc   (w_tc)
  );

  // Frame sequencing: latch a transfer on start, step bit index per period,
  // and at frame end either return to idle or restart the same word.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_sel   <= LOW_SPEED;
      r_mode  <= IDLE_LOW;
      r_idx   <= '0;
    end else if (i_stop) begin
      r_state <= IDLE;
      r_mode  <= IDLE_LOW;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_state <= SEND;
      r_word  <= i_data;
      r_sel   <= i_sel_freq;
      r_mode  <= i_idle_mode;
      r_idx   <= '0;
    end else if (w_send && w_tc) begin
      if (w_last) begin
        r_idx <= '0;
`ifdef DIFF_FREQ_REPEAT_EN
        if (r_mode == IDLE_REPEAT) begin
          r_state <= SEND;
        end else begin
          r_state <= IDLE;
        end
`else
        r_state <= IDLE;
`endif
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Output stage: line is a registered copy of w_line; the done tick trails
  // the frame-end edge by one cycle so it lines up with the idle level.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_data <= 1'b0;
      r_fend <= 1'b0;
      r_done <= 1'b0;
    end else if (i_stop) begin
      r_data <= 1'b0;
      r_fend <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_data <= w_line;
      r_fend <= w_frame_end;
      r_done <= r_fend;
    end
  end

  assign o_data      = r_data;
  assign o_done_tick = r_done;

endmodule

// File: tb/tb_diff_freq_serializer.sv
// Self-checking bench for diff_freq_serializer: directed table, corner
// sequences and randomized traffic against a timing-formula reference model.
module tb_diff_freq_serializer;

`ifdef DIFF_FREQ_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_sel_freq;
  logic       i_start;
  logic       i_stop;
  logic [1:0] i_idle_mode;
  logic [7:0] i_data;
  logic       o_data;
  logic       o_done_tick;

  diff_freq_serializer #(.DATA_BIT(8), .LOW_FREQ(20), .HIGH_FREQ(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sel_freq  (i_sel_freq),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_idle_mode (i_idle_mode),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_done_tick (o_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: a frame is described by its start edge m_ks and
  // bit period m_n; outputs follow from edge arithmetic.
  bit         m_active;
  bit         m_rep;
  int         m_ks;
  int         m_n;
  int         m_next_done;
  logic [7:0] m_word;
  logic [1:0] m_mode;
  logic       exp_data;
  logic       exp_done;

  function automatic logic ilvl(input logic [1:0] mode, input logic [7:0] word);
    if (mode == 2'd1) return 1'b1;
    if (mode == 2'd2) return word[7];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_rep = 0; m_ks = 0; m_n = 20; m_next_done = -1;
    m_word = 8'h00; m_mode = 2'd0; exp_data = 1'b0; exp_done = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic sl,
                            input logic [1:0] md, input logic [7:0] dt);
    int   d;
    logic old_idle;
    if (sp) begin
      m_active = 0; m_rep = 0; m_mode = 2'd0; m_next_done = -1;
      exp_data = 1'b0; exp_done = 1'b0;
      return;
    end
    exp_done = (cyc == m_next_done);
    if (m_active && !m_rep && cyc > m_ks + 8 * m_n) m_active = 0;
    old_idle = ilvl(m_mode, m_word);
    if (!m_active && st) begin
      m_active = 1; m_ks = cyc; m_word = dt; m_mode = md;
      m_n = sl ? 10 : 20;
      m_rep = REPEAT && (md == 2'd3);
      m_next_done = cyc + 8 * m_n + 1;
    end
    if (m_active && m_rep && cyc > m_ks + 8 * m_n) begin
      m_ks = m_ks + 8 * m_n;
      m_next_done = m_ks + 8 * m_n + 1;
    end
    if (m_active) begin
      d = cyc - m_ks;
      exp_data = (d == 0) ? old_idle : m_word[(d - 1) / m_n];
    end else begin
      exp_data = ilvl(m_mode, m_word);
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance to the edge, update model, compare.
  task automatic step(input logic st, input logic sp, input logic sl,
                      input logic [1:0] md, input logic [7:0] dt);
    i_start = st; i_stop = sp; i_sel_freq = sl; i_idle_mode = md; i_data = dt;
    @(posedge clk);
    cyc++;
    model_edge(st, sp, sl, md, dt);
    #1;
    chk("line", o_data, exp_data);
    chk("done", o_done_tick, exp_done);
  endtask

  // Idle steps until a done tick is seen; returns steps taken (bounded).
  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (lat < 400) begin
      step(0, 0, 0, 2'd0, 8'h00);
      lat++;
      if (o_done_tick) break;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       sel;
    logic [1:0] mode;
    int         lat;
    logic       line_after;
  } vec_t;

  vec_t tv[5];
  int   lat;
  int   dones;

  initial begin
    tv[0] = '{data: 8'h55, sel: 1'b1, mode: 2'd0, lat: 81,  line_after: 1'b0};
    tv[1] = '{data: 8'h55, sel: 1'b0, mode: 2'd0, lat: 161, line_after: 1'b0};
    tv[2] = '{data: 8'h81, sel: 1'b1, mode: 2'd1, lat: 81,  line_after: 1'b1};
    tv[3] = '{data: 8'h81, sel: 1'b1, mode: 2'd2, lat: 81,  line_after: 1'b1};
    tv[4] = '{data: 8'h01, sel: 1'b1, mode: 2'd2, lat: 81,  line_after: 1'b0};

    model_reset();
    rst_n = 1'b1;
    i_start = 0; i_stop = 0; i_sel_freq = 0; i_idle_mode = 2'd0; i_data = 8'h00;
    #1;
    chk("reset_line", o_data, 1'b0);
    chk("reset_done", o_done_tick, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Directed table; each start after the first lands in the previous done tick.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, tv[i].sel, tv[i].mode, tv[i].data);
      wait_done(0, lat);
      chk_int("table_latency", lat, tv[i].lat);
      chk("table_line_after", o_data, tv[i].line_after);
    end

    // Start pulsed mid-frame must be ignored.
    step(0, 0, 0, 2'd0, 8'h00);
    step(1, 0, 1, 2'd0, 8'h3C);
    repeat (24) step(0, 0, 0, 2'd0, 8'h00);
    step(1, 0, 0, 2'd1, 8'hFF);
    wait_done(25, lat);
    chk_int("ignored_start_latency", lat, 81);
    chk("ignored_start_line", o_data, 1'b0);

    // Start and stop together in idle: nothing happens.
    step(1, 1, 1, 2'd1, 8'hFF);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 2'd0, 8'h00);
      if (o_done_tick) dones++;
    end
    chk_int("start_stop_dones", dones, 0);
    chk("start_stop_line", o_data, 1'b0);

    // Mode 11: repeating frames when enabled, single idle-low frame otherwise.
    step(1, 0, 1, 2'd3, 8'hA5);
    dones = 0;
    for (int i = 0; i < 250; i++) begin
      step(0, 0, 0, 2'd0, 8'h00);
      if (o_done_tick) dones++;
    end
    chk_int("repeat_dones", dones, REPEAT ? 3 : 1);
    step(0, 1, 0, 2'd0, 8'h00);
    chk("stop_line", o_data, 1'b0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 2'd0, 8'h00);
      if (o_done_tick) dones++;
    end
    chk_int("after_stop_dones", dones, 0);

    // Asynchronous reset mid-frame, then a clean full frame.
    step(1, 0, 0, 2'd1, 8'hC3);
    repeat (30) step(0, 0, 0, 2'd0, 8'h00);
    #3 rst_n = 1'b1;
    #1;
    chk("async_reset_line", o_data, 1'b0);
    chk("async_reset_done", o_done_tick, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 2'd0, 8'hC3);
    wait_done(0, lat);
    chk_int("post_reset_latency", lat, 161);
    chk("post_reset_line", o_data, 1'b0);

    // Randomized traffic with stray starts and occasional stops.
    for (int i = 0; i < 40; i++) begin
      int n;
      step(1, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      n = $urandom_range(20, 220);
      for (int j = 0; j < n; j++) begin
        step(($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diff_freq_serializer.md
# diff_freq_serializer

Parallel-to-serial transmitter that shifts a DATA_BIT-wide word out on a single line, LSB first, at one of two bit rates derived from the system clock. Each transfer selects the bit rate and the line level to drive between frames, and a one-cycle done tick marks each frame's end. It sits between a register/control front end and a single-wire output pin. The RTL module name is diff_freq_serializer.

## Interface
- DATA_BIT, 8: bits per frame.
- LOW_FREQ, 20: clk cycles per bit in low-speed mode (1..255).
- HIGH_FREQ, 10: clk cycles per bit in high-speed mode (1..255).
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high.
- i_sel_freq  input  1  0 = low speed (LOW_FREQ), 1 = high speed (HIGH_FREQ); sampled with i_start.
- i_start  input  1  one-cycle start request.
- i_stop  input  1  abort / end-repeat request.
- i_idle_mode  input  2  00 idle low, 01 idle high, 10 keep last bit, 11 repeat frame; sampled with i_start.
- i_data  input  DATA_BIT  word to send; sampled with i_start.
- o_data  output  1  serial line.
- o_done_tick  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, SEND.
- IDLE: i_start=1 latches i_data, i_sel_freq and i_idle_mode; next state SEND with bit index 0 and period counter 0. i_start is ignored in SEND.
- SEND: o_data = latched bit[index]. The period counter runs 0..N-1, where N = HIGH_FREQ if the latched sel is 1, else LOW_FREQ. At N-1 the index increments and the counter clears. After bit DATA_BIT-1 completes, the frame ends.
- Frame end:
  - o_done_tick = 1 for exactly one cycle.
  - Modes 00, 01, 10: return to IDLE. o_data = 0, 1, or the last bit sent (bit DATA_BIT-1), held until the next frame.
  - Mode 11: immediately restart at bit 0 with the same latched word, sel and mode. No gap; the done tick pulses every frame.
- i_stop=1 in any state: go to IDLE next cycle, o_data = 0, no done tick, latched mode cleared to 00. i_stop has priority over a simultaneous i_start.
- Counter widths: period counter 8 bits; index counter $clog2(DATA_BIT) bits. No wrap beyond DATA_BIT-1.

## Timing
- Reset values: o_data = 0, o_done_tick = 0, state IDLE, latched mode 00, counters 0.
- Let the start be sampled at edge k.
  - o_data shows bit0 from edge k+1 for N cycles, and bit i during edges k+1+iN .. k+(i+1)N.
  - o_done_tick is high from edge k+DATA_BIT·N+1 for one cycle. In that same cycle o_data is at the idle level, or at bit0 of the next frame in mode 11.
- An i_start high during the done-tick cycle is accepted; there is no back-to-back dead time beyond that cycle.
- Reset asserted mid-frame forces reset values immediately, asynchronously.

## Configuration
- DIFF_FREQ_REPEAT_EN defined: mode 11 behaves as repeat, as above.
- DIFF_FREQ_REPEAT_EN undefined: mode 11 behaves exactly as mode 00 (single frame, idle low), and the restart logic is not compiled.

## Structure
- Shared package diff_freq_serializer_pkg holds:
  - idle-mode constants IDLE_LOW, IDLE_HIGH, IDLE_KEEP, IDLE_REPEAT;
  - speed constants LOW_SPEED = 0, HIGH_SPEED = 1;
  - state enum {IDLE, SEND}.
- One sub-module, bit_period_timer: 8-bit counter with load value N, clear, and a terminal-count pulse; instantiated once.

## Test plan
- 8'h55, high speed, idle low -> o_data toggles 1,0,1,0,… with 10 cycles per bit; done tick 81 cycles after start; line then 0.
- 8'h55, low speed, idle low, started during the previous done tick -> 20 cycles per bit, done tick after 161 cycles, no lost start.
- 8'h81, high speed, idle high then idle keep -> after done, o_data = 1 in both cases; with 8'h01 and keep, o_data = 0 after done.
- 8'hA5, mode 11, macro defined -> continuous frames with a done tick every 80 cycles; i_stop mid-frame -> o_data 0 next cycle, no done tick, IDLE. Same stimulus with macro undefined -> single frame, idle low.
- i_start pulsed during SEND -> ignored, current frame unaffected. i_start and i_stop together in IDLE -> stays IDLE.
- Reset asserted mid-frame -> o_data = 0, o_done_tick = 0 immediately; a new start afterwards sends a full, correct frame.
